im_loader: RTL

Sequential writer for the instruction memory: accepts a byte stream over a valid/ready handshake, packs each group of four bytes into a 32-bit instruction, and drives the memory's synchronous write port at consecutive word addresses. It sits between the boot/host interface and the instruction memory. It lets a program image be loaded at run time instead of being preset in the memory array. Once loading is done, the processor reads the memory through its normal combinational read path.

---
 rtl/im_loader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/im_loader.sv
// im_loader: packs a big-endian byte stream into 32-bit words and writes them to instruction memory.
// Latency: 4th byte accepted at edge k -> we/waddr/wdata valid k..k+1; minimum 5 cycles per word.
// Backpressure: in_ready is high only while receiving; it drops for the write cycle; gaps in in_valid stall the loader.
module im_loader #(
  parameter int SIZE_IM = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  num_words,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  words_written
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  r_state;
  logic [7:0]  r_len;
  logic [1:0]  r_byte_cnt;
  logic [7:0]  r_word_idx;
  logic [23:0] r_buf;
  logic        r_we;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [7:0]  r_words_written;

  logic w_idle_like;
  logic w_start_ok;
  logic w_too_big;
  logic w_accept;
  logic w_word_full;
  logic w_last;

  // IDLE and DONE both accept a new start; busy states ignore it.
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start_ok  = start && w_idle_like;
  assign w_too_big   = (32'(num_words) > 32'(SIZE_IM));
  assign w_accept    = (r_state == S_RECV) && in_valid;
  assign w_word_full = w_accept && (r_byte_cnt == 2'd3);
  assign w_last      = ((r_word_idx + 8'd1) == r_len);

  // Control: state sequencing, length latch, word/byte counters and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_len           <= 8'd0;
      r_byte_cnt      <= 2'd0;
      r_word_idx      <= 8'd0;
      r_err           <= 1'b0;
      r_words_written <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_len           <= num_words;
            r_err           <= 1'b0;
            r_words_written <= 8'd0;
            r_byte_cnt      <= 2'd0;
            r_word_idx      <= 8'd0;
            if (num_words == 8'd0) begin
              r_state <= S_DONE;
            end else if (w_too_big) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_RECV;
            end
          end
        end
        S_RECV: begin
          if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_word_full) begin
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_word_idx      <= r_word_idx + 8'd1;
          r_words_written <= r_words_written + 8'd1;
          r_byte_cnt      <= 2'd0;
          r_state         <= w_last ? S_DONE : S_RECV;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath: shift bytes into the buffer and register the memory write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf   <= 24'd0;
      r_we    <= 1'b0;
      r_waddr <= 32'd0;
      r_wdata <= 32'd0;
    end else begin
      r_we <= 1'b0;
      if (w_start_ok) begin
        r_buf <= 24'd0;
      end else if (w_accept) begin
        r_buf <= {r_buf[15:0], in_byte};
        if (w_word_full) begin
          r_we    <= 1'b1;
          r_wdata <= {r_buf, in_byte};
          r_waddr <= {22'd0, r_word_idx, 2'b00};
        end
      end
    end
  end

  assign in_ready      = (r_state == S_RECV);
  assign busy          = (r_state == S_RECV) || (r_state == S_WRITE);
  assign done          = (r_state == S_DONE);
  assign we            = r_we;
  assign waddr         = r_waddr;
  assign wdata         = r_wdata;
  assign err           = r_err;
  assign words_written = r_words_written;

endmodule
